// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu : byte-addressed data memory with a RISC-V style load/store port.
//
// Storage is 2^(ADDR_SIZE-2) little-endian 32-bit words. Requests are accepted
// on req_valid && req_ready. Each accepted request produces exactly one
// rsp_valid pulse. Aligned requests respond one cycle after acceptance.
//
// Optional feature macro: DMEM_MISALIGN_EN
//   defined   : misaligned h/hu/w accesses are split over two adjacent words
//               (one extra SPLIT cycle, response two cycles after acceptance)
//   undefined : misaligned accesses respond with rsp_fault and do not write
//
// Parameters
//   ADDR_SIZE  log2 of storage bytes
//   INIT_ZERO  1: reset clears rsp_rdata as well as the response flags;
//              storage is never cleared by reset
//
// Ports
//   clk                 clock, all state changes on its rising edge
//   reset               synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_we              1 = store, 0 = load
//   req_size            funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   req_addr            byte address, upper bits wrap
//   req_wdata           store data, low-order bytes used for b/h
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           extended load data, 0 for stores and faults
//   rsp_fault           bad size or disallowed misalignment
// -----------------------------------------------------------------------------
module dmem_lsu #(
    parameter int ADDR_SIZE = 16,
    parameter int INIT_ZERO = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int WA    = ADDR_SIZE - 2;
    localparam int DEPTH = 1 << WA;

`ifdef DMEM_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef enum logic {IDLE, SPLIT} state_t;

    logic [31:0] mem [DEPTH];

    state_t          state_q, state_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_fault_q, rsp_fault_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;

    // request captured for the second beat of a split access
    logic            sp_we_q, sp_we_d;
    logic [2:0]      sp_size_q, sp_size_d;
    logic [1:0]      sp_off_q, sp_off_d;
    logic [WA-1:0]   sp_widx_q, sp_widx_d;
    logic [3:0]      sp_be_q, sp_be_d;
    logic [31:0]     sp_wdata_q, sp_wdata_d;
    logic [31:0]     sp_lo_q, sp_lo_d;

    logic            mem_we;
    logic [WA-1:0]   mem_widx;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdata;

    logic [1:0]      req_off;
    logic [WA-1:0]   req_widx;
    logic [3:0]      size_mask;
    logic            size_bad;
    logic            misalign;
    logic            accept;
    logic [7:0]      be_full;
    logic [63:0]     wd_full;
    logic [63:0]     split_cat;
    logic [31:0]     rd_word;
    logic [31:0]     hi_word;

    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_SIZE];

    function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [2:0] size);
        case (size)
            3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_ext = {24'b0, raw[7:0]};
            3'b101:  load_ext = {16'b0, raw[15:0]};
            default: load_ext = raw;
        endcase
    endfunction

    always_comb begin
        req_off  = req_addr[1:0];
        req_widx = req_addr[ADDR_SIZE-1:2];

        size_bad = 1'b0;
        case (req_size)
            3'b000, 3'b100: size_mask = 4'b0001;
            3'b001, 3'b101: size_mask = 4'b0011;
            3'b010:         size_mask = 4'b1111;
            default: begin
                size_mask = 4'b0000;
                size_bad  = 1'b1;
            end
        endcase

        misalign = ((size_mask == 4'b0011) && req_off[0]) ||
                   ((size_mask == 4'b1111) && (req_off != 2'b00));

        // lanes 3:0 land in word W, lanes 7:4 spill into word W+1
        be_full = {4'b0000, size_mask} << req_off;
        wd_full = {32'b0, req_wdata} << {req_off, 3'b000};

        // reset has priority over a same-cycle request
        accept  = req_valid && req_ready_q && !reset;

        rd_word   = mem[req_widx];
        hi_word   = mem[sp_widx_q + WA'(1)];
        split_cat = {hi_word, sp_lo_q} >> {sp_off_q, 3'b000};

        state_d     = state_q;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = '0;
        sp_we_d     = sp_we_q;
        sp_size_d   = sp_size_q;
        sp_off_d    = sp_off_q;
        sp_widx_d   = sp_widx_q;
        sp_be_d     = sp_be_q;
        sp_wdata_d  = sp_wdata_q;
        sp_lo_d     = sp_lo_q;
        mem_we      = 1'b0;
        mem_widx    = req_widx;
        mem_be      = be_full[3:0];
        mem_wdata   = wd_full[31:0];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (size_bad || (misalign && !MIS_EN)) begin
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else if (misalign) begin
                        state_d     = SPLIT;
                        req_ready_d = 1'b0;
                        mem_we      = req_we;
                        sp_we_d     = req_we;
                        sp_size_d   = req_size;
                        sp_off_d    = req_off;
                        sp_widx_d   = req_widx;
                        sp_be_d     = be_full[7:4];
                        sp_wdata_d  = wd_full[63:32];
                        sp_lo_d     = rd_word;
                    end else begin
                        rsp_valid_d = 1'b1;
                        mem_we      = req_we;
                        if (!req_we)
                            rsp_rdata_d = load_ext(rd_word >> {req_off, 3'b000}, req_size);
                    end
                end
            end
            SPLIT: begin
                state_d = IDLE;
                if (!reset) begin
                    rsp_valid_d = 1'b1;
                    mem_we      = sp_we_q;
                    mem_widx    = sp_widx_q + WA'(1);
                    mem_be      = sp_be_q;
                    mem_wdata   = sp_wdata_q;
                    if (!sp_we_q)
                        rsp_rdata_d = load_ext(split_cat[31:0], sp_size_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        sp_we_q    <= sp_we_d;
        sp_size_q  <= sp_size_d;
        sp_off_q   <= sp_off_d;
        sp_widx_q  <= sp_widx_d;
        sp_be_q    <= sp_be_d;
        sp_wdata_q <= sp_wdata_d;
        sp_lo_q    <= sp_lo_d;
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            if (INIT_ZERO != 0)
                rsp_rdata_q <= '0;
            else
                rsp_rdata_q <= rsp_rdata_d;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i])
                    mem[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_SIZE(16), .INIT_ZERO(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // called 1 time unit after a rising edge; returns 1 time unit after the accepting edge
    task automatic send(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // single-beat request: response expected right after the accepting edge
    task automatic acc1(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_f);
        chk({tag, "/ready"}, 32'(req_ready), 32'd1);
        send(we, size, addr, wdata);
        chk({tag, "/valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "/rdata"}, rsp_rdata, exp_rd);
        chk({tag, "/fault"}, 32'(rsp_fault), 32'(exp_f));
    endtask

    // split request: stall one cycle, response after the SPLIT edge
    task automatic acc2(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd);
        chk({tag, "/ready"}, 32'(req_ready), 32'd1);
        send(we, size, addr, wdata);
        chk({tag, "/split_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "/split_valid"}, 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "/valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "/rdata"}, rsp_rdata, exp_rd);
        chk({tag, "/fault"}, 32'(rsp_fault), 32'd0);
        chk({tag, "/ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = SZ_W;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/valid", 32'(rsp_valid), 32'd0);
        chk("rst/fault", 32'(rsp_fault), 32'd0);
        chk("rst/rdata", rsp_rdata, 32'd0);
        chk("rst/ready", 32'(req_ready), 32'd1);
        reset = 1'b0;

        // byte lanes and extension
        acc1("sw100",  1'b1, SZ_W,  32'h100, 32'h80FF1234, 32'h0, 1'b0);
        acc1("lb101",  1'b0, SZ_B,  32'h101, 32'h0, 32'h00000012, 1'b0);
        acc1("lbu103", 1'b0, SZ_BU, 32'h103, 32'h0, 32'h00000080, 1'b0);
        acc1("lh102",  1'b0, SZ_H,  32'h102, 32'h0, 32'hFFFF80FF, 1'b0);
        acc1("lb103",  1'b0, SZ_B,  32'h103, 32'h0, 32'hFFFFFF80, 1'b0);
        acc1("lhu102", 1'b0, SZ_HU, 32'h102, 32'h0, 32'h000080FF, 1'b0);
        acc1("lw100",  1'b0, SZ_W,  32'h100, 32'h0, 32'h80FF1234, 1'b0);

        // per-byte enables, store followed immediately by load
        acc1("sw200",  1'b1, SZ_W,  32'h200, 32'hAABBCCDD, 32'h0, 1'b0);
        acc1("sb202",  1'b1, SZ_B,  32'h202, 32'h99999911, 32'h0, 1'b0);
        acc1("lw200a", 1'b0, SZ_W,  32'h200, 32'h0, 32'hAA11CCDD, 1'b0);
        acc1("sh200",  1'b1, SZ_H,  32'h200, 32'hFFFF5566, 32'h0, 1'b0);
        acc1("lw200b", 1'b0, SZ_W,  32'h200, 32'h0, 32'hAA115566, 1'b0);
        @(posedge clk);
        #1;
        chk("idle/valid_pulse", 32'(rsp_valid), 32'd0);

        // illegal sizes
        acc1("sw500",   1'b1, SZ_W,   32'h500, 32'hCAFEF00D, 32'h0, 1'b0);
        acc1("bad011",  1'b1, 3'b011, 32'h500, 32'h12345678, 32'h0, 1'b1);
        acc1("bad110",  1'b0, 3'b110, 32'h500, 32'h0, 32'h0, 1'b1);
        acc1("bad111",  1'b1, 3'b111, 32'h500, 32'hFFFFFFFF, 32'h0, 1'b1);
        acc1("lw500",   1'b0, SZ_W,   32'h500, 32'h0, 32'hCAFEF00D, 1'b0);

        // address wrap
        acc1("swFFFC",   1'b1, SZ_W, 32'h0000FFFC, 32'h0BADBEEF, 32'h0, 1'b0);
        acc1("lw1FFFC",  1'b0, SZ_W, 32'h0001FFFC, 32'h0, 32'h0BADBEEF, 1'b0);
        acc1("sw1FFF8",  1'b1, SZ_W, 32'h0001FFF8, 32'h13579BDF, 32'h0, 1'b0);
        acc1("lwFFF8",   1'b0, SZ_W, 32'h0000FFF8, 32'h0, 32'h13579BDF, 1'b0);

        // reset wins over a same-cycle request
        acc1("sw600", 1'b1, SZ_W, 32'h600, 32'h12345678, 32'h0, 1'b0);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_W;
        req_addr  = 32'h600;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        chk("rstreq/valid", 32'(rsp_valid), 32'd0);
        chk("rstreq/ready", 32'(req_ready), 32'd1);
        acc1("lw600", 1'b0, SZ_W, 32'h600, 32'h0, 32'h12345678, 1'b0);

        // aligned half inside a word is never misaligned
        acc1("sw400",  1'b1, SZ_W, 32'h400, 32'h11223344, 32'h0, 1'b0);
        acc1("lh402",  1'b0, SZ_H, 32'h402, 32'h0, 32'h00001122, 1'b0);

`ifdef DMEM_MISALIGN_EN
        acc1("sw300", 1'b1, SZ_W, 32'h300, 32'h0, 32'h0, 1'b0);
        acc1("sw304", 1'b1, SZ_W, 32'h304, 32'h0, 32'h0, 1'b0);
        acc1("sw800", 1'b1, SZ_W, 32'h800, 32'h01020304, 32'h0, 1'b0);
        // split store; a request presented during SPLIT must be ignored
        chk("sw301/ready", 32'(req_ready), 32'd1);
        send(1'b1, SZ_W, 32'h301, 32'h44332211);
        chk("sw301/split_ready", 32'(req_ready), 32'd0);
        chk("sw301/split_valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_W;
        req_addr  = 32'h800;
        req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("sw301/valid", 32'(rsp_valid), 32'd1);
        chk("sw301/fault", 32'(rsp_fault), 32'd0);
        chk("sw301/ready_after", 32'(req_ready), 32'd1);
        acc1("lw800", 1'b0, SZ_W, 32'h800, 32'h0, 32'h01020304, 1'b0);

        acc2("lw301", 1'b0, SZ_W, 32'h301, 32'h0, 32'h44332211);
        acc1("lw300", 1'b0, SZ_W, 32'h300, 32'h0, 32'h33221100, 1'b0);
        acc1("lw304", 1'b0, SZ_W, 32'h304, 32'h0, 32'h00000044, 1'b0);
        acc2("lh303", 1'b0, SZ_H, 32'h303, 32'h0, 32'h00004433);

        // split across the top of storage
        acc1("sw0000", 1'b1, SZ_W, 32'h0000, 32'hA5A5A5A5, 32'h0, 1'b0);
        acc1("swFFFC2", 1'b1, SZ_W, 32'hFFFC, 32'h5A5A5A5A, 32'h0, 1'b0);
        acc2("swFFFE", 1'b1, SZ_W, 32'hFFFE, 32'hDDCCBBAA, 32'h0);
        acc1("lwFFFC2", 1'b0, SZ_W, 32'hFFFC, 32'h0, 32'hBBAA5A5A, 1'b0);
        acc1("lw0000", 1'b0, SZ_W, 32'h0000, 32'h0, 32'hA5A5DDCC, 1'b0);
        acc2("lwFFFE", 1'b0, SZ_W, 32'hFFFE, 32'h0, 32'hDDCCBBAA);

        // reset during SPLIT abandons the second beat
        acc1("sw700", 1'b1, SZ_W, 32'h700, 32'h0, 32'h0, 1'b0);
        acc1("sw704", 1'b1, SZ_W, 32'h704, 32'h0, 32'h0, 1'b0);
        send(1'b1, SZ_W, 32'h701, 32'h77665544);
        chk("rstsplit/in_split", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rstsplit/valid", 32'(rsp_valid), 32'd0);
        chk("rstsplit/ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("rstsplit/no_late_valid", 32'(rsp_valid), 32'd0);
        acc1("lw700", 1'b0, SZ_W, 32'h700, 32'h0, 32'h66554400, 1'b0);
        acc1("lw704", 1'b0, SZ_W, 32'h704, 32'h0, 32'h00000000, 1'b0);
`else
        acc1("sh401",  1'b1, SZ_H,  32'h401, 32'h0000BEEF, 32'h0, 1'b1);
        acc1("lh401",  1'b0, SZ_H,  32'h401, 32'h0, 32'h0, 1'b1);
        acc1("lhu403", 1'b0, SZ_HU, 32'h403, 32'h0, 32'h0, 1'b1);
        acc1("sw402",  1'b1, SZ_W,  32'h402, 32'hFFFFFFFF, 32'h0, 1'b1);
        acc1("lw302",  1'b0, SZ_W,  32'h302, 32'h0, 32'h0, 1'b1);
        acc1("lw400",  1'b0, SZ_W,  32'h400, 32'h0, 32'h11223344, 1'b0);
        chk("nosplit/ready", 32'(req_ready), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 16, log2 of storage bytes; storage is 2^(ADDR_SIZE-2) 32-bit words.
REQ-002 SHALL have parameter INIT_ZERO, default 1; when 1, reset clears the response registers only and never clears storage.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready at a rising edge.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 3, RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-009 SHALL have port req_addr, input, 32, byte address; bits above ADDR_SIZE-1 ignored (address wraps).
REQ-010 SHALL have port req_wdata, input, 32, store data, low-order bytes used for b/h.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle completion pulse for every accepted request.
REQ-012 SHALL have port rsp_rdata, output, 32, load result, sign/zero extended; 0 for stores and faults.
REQ-013 SHALL have port rsp_fault, output, 1, qualified by rsp_valid; bad size or disallowed misalignment.

Function
REQ-014 SHALL order bytes little-endian: byte at address A drives bits 7:0 of the returned word.
REQ-015 SHALL complete an aligned access accepted at edge N with rsp_valid high for the cycle after edge N (latency 1, synchronous read).
REQ-016 SHALL accept back-to-back aligned requests every cycle while in state IDLE (req_ready = 1 in IDLE).
REQ-017 SHALL write only the addressed bytes on a store (per-byte enables); other bytes of the word unchanged.
REQ-018 SHALL sign-extend for b/h and zero-extend for bu/hu; w returns all 32 bits.
REQ-019 SHALL treat req_size 011, 110, 111 as fault: no storage write, rsp_fault = 1, rsp_rdata = 0, latency 1.
REQ-020 SHALL define misaligned as h/hu with addr[0] = 1, or w with addr[1:0] != 00.
REQ-021 SHALL implement FSM states IDLE and SPLIT; IDLE -> SPLIT only on acceptance of a misaligned access with DMEM_MISALIGN_EN defined; SPLIT -> IDLE unconditionally after one cycle.
REQ-022 SHALL hold req_ready = 0 in SPLIT; the captured request is not affected by input changes during SPLIT.
REQ-023 SHALL, in a split access, access word W at the acceptance edge and word W+1 (modulo storage size) at the SPLIT edge; rsp_valid is asserted in the cycle after the SPLIT edge (latency 2).
REQ-024 SHALL, for a split store, write the low-address bytes at the first edge and the remaining bytes at the second edge.
REQ-025 SHALL resolve a load and store to the same word on consecutive cycles so that the load returns the newly stored data (write-before-read ordering by edge).

Reset
REQ-026 SHALL, on reset, force state IDLE, rsp_valid = 0, rsp_fault = 0, rsp_rdata = 0; req_ready = 1 from the first cycle after reset.
REQ-027 SHALL, on reset during SPLIT, abandon the access: no second-beat write, no response; first-beat bytes remain written.
REQ-028 SHALL ignore req_valid in any cycle where reset is high (no write, no acceptance).

Configuration
REQ-029 SHALL, with DMEM_MISALIGN_EN defined, service misaligned accesses via SPLIT per REQ-021..REQ-024, with rsp_fault = 0.
REQ-030 SHALL, without DMEM_MISALIGN_EN, respond to misaligned accesses with latency 1, rsp_fault = 1, rsp_rdata = 0, no storage write, with state SPLIT unreachable.

Verification
REQ-031 SHALL pass: sw 0x80FF1234 @0x100, then lb @0x101 -> 0x00000012; lbu @0x103 -> 0x00000080; lh @0x102 -> 0xFFFF80FF.
REQ-032 SHALL pass: sw 0xAABBCCDD @0x200, then sb 0x11 @0x202, then lw @0x200 -> 0xAA11CCDD, each response 1 cycle after acceptance.
REQ-033 SHALL pass with DMEM_MISALIGN_EN: sw 0x44332211 @0x301, then lw @0x301 -> 0x44332211; req_ready low 1 cycle; rsp 2 cycles after acceptance; rsp_fault 0.
REQ-034 SHALL pass without DMEM_MISALIGN_EN: lh @0x401 -> rsp_fault 1, rsp_rdata 0; prior word at 0x400 unchanged after sh @0x401.
REQ-035 SHALL pass: req_size 011 store @0x500 -> rsp_fault 1, word at 0x500 unchanged; reset asserted in SPLIT cycle -> no rsp_valid, req_ready 1 next cycle.
REQ-036 SHALL pass wrap: ADDR_SIZE 16, lw @0x0001FFFC returns the word at 0xFFFC; with DMEM_MISALIGN_EN, sw @0xFFFE writes bytes 0xFFFE, 0xFFFF, 0x0000, 0x0001.
